// File: rtl/quadrature_step_decoder.sv
// Purpose : quadrature encoder front end; sync + debounce enc_a/enc_b, decode Gray steps into step/A_D/error.
// Latency : SYNC_STAGES+DEBOUNCE_CYCLES+1 clk posedges from an enc edge to step/error (7 with defaults).
// Backpressure: none; free-running pulse outputs, the counter must consume step on the cycle it is high.
//
// Ports:
//   clk    in   system clock, all logic on posedge
//   reset  in   synchronous, active-high reset
//   enc_a  in   encoder channel A (asynchronous, bouncy)
//   enc_b  in   encoder channel B (asynchronous, bouncy)
//   step   out  registered 1-cycle pulse per accepted step
//   A_D    out  direction level, 1 = up (CW), 0 = down (CCW); only changes with step
//   error  out  registered 1-cycle pulse when both filtered bits change together
//   state  out  filtered {A,B} Gray state
//
// Build option: define QUAD_X4_EN for x4 decoding (a step on every valid transition).
// Default (undefined) is x1 decoding: a step only on entering 00.
module quadrature_step_decoder #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enc_a,
  input  logic       enc_b,
  output logic       step,
  output logic       A_D,
  output logic       error,
  output logic [1:0] state
);

  localparam int DBC_BITS      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SETTLE_CYCLES = SYNC_STAGES + DEBOUNCE_CYCLES + 1;
  localparam int SETTLE_BITS   = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [1:0] {
    TR_NONE,
    TR_UP,
    TR_DOWN,
    TR_ILLEGAL
  } trans_t;

  // Bit 1 carries channel A, bit 0 channel B, so {A,B} vectors line up with state.
  logic [SYNC_STAGES-1:0]     sync_a_q;
  logic [SYNC_STAGES-1:0]     sync_b_q;
  logic [1:0]                 sync_ab;
  logic [1:0][DBC_BITS-1:0]   dbc_cnt;
  logic [1:0]                 filt;
  logic [1:0]                 prev;
  logic [SETTLE_BITS-1:0]     settle_cnt;

  trans_t                     trans;
  logic                       step_d;
  logic                       error_d;
  logic                       ad_d;

  assign sync_ab = {sync_a_q[SYNC_STAGES-1], sync_b_q[SYNC_STAGES-1]};
  assign state   = filt;

  // Metastability chains; enc_x enters at bit 0 and exits at the top bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_a_q <= '0;
      sync_b_q <= '0;
    end else begin
      sync_a_q <= {sync_a_q[SYNC_STAGES-2:0], enc_a};
      sync_b_q <= {sync_b_q[SYNC_STAGES-2:0], enc_b};
    end
  end

  // Per-channel debounce. The counter tracks how many consecutive cycles the
  // synced value has disagreed with the filtered one; the filter flips on the
  // DEBOUNCE_CYCLES-th disagreeing cycle. Any agreeing cycle restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      dbc_cnt <= '0;
      filt    <= 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync_ab[i] == filt[i]) begin
          dbc_cnt[i] <= '0;
        end else if (dbc_cnt[i] == DBC_BITS'(DEBOUNCE_CYCLES - 1)) begin
          filt[i]    <= sync_ab[i];
          dbc_cnt[i] <= '0;
        end else begin
          dbc_cnt[i] <= dbc_cnt[i] + DBC_BITS'(1);
        end
      end
    end
  end

  // Classify the filtered transition. CW order is 00->01->11->10->00; any other
  // single-bit change is the reverse (CCW) direction.
  always_comb begin
    trans = TR_NONE;
    if (filt != prev) begin
      if (filt == ~prev) begin
        trans = TR_ILLEGAL;
      end else begin
        unique case ({prev, filt})
          4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: trans = TR_UP;
          default:                                trans = TR_DOWN;
        endcase
      end
    end
  end

  always_comb begin
    step_d  = 1'b0;
    error_d = 1'b0;
    ad_d    = A_D;

    unique case (trans)
`ifdef QUAD_X4_EN
      TR_UP: begin
        step_d = 1'b1;
        ad_d   = 1'b1;
      end
      TR_DOWN: begin
        step_d = 1'b1;
        ad_d   = 1'b0;
      end
`else
      // x1: one step per detent, emitted on arrival at 00. Arriving from 10
      // is the CW direction, arriving from 01 the CCW direction.
      TR_UP: begin
        if (filt == 2'b00) begin
          step_d = 1'b1;
          ad_d   = 1'b1;
        end
      end
      TR_DOWN: begin
        if (filt == 2'b00) begin
          step_d = 1'b1;
          ad_d   = 1'b0;
        end
      end
`endif
      TR_ILLEGAL: error_d = 1'b1;
      default: ;
    endcase

    // Settle window: a resting non-zero encoder position flows through the
    // filters right after reset; swallow whatever that decodes to.
    if (settle_cnt != '0) begin
      step_d  = 1'b0;
      error_d = 1'b0;
      ad_d    = A_D;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev       <= 2'b00;
      step       <= 1'b0;
      error      <= 1'b0;
      A_D        <= 1'b1;
      settle_cnt <= SETTLE_BITS'(SETTLE_CYCLES);
    end else begin
      prev  <= filt;
      step  <= step_d;
      error <= error_d;
      A_D   <= ad_d;
      if (settle_cnt != '0) begin
        settle_cnt <= settle_cnt - SETTLE_BITS'(1);
      end
    end
  end

endmodule
